ahb_output_stage_rr: RTL and testbench
======================================

# ahb_output_stage_rr

Parametrised bus-matrix output stage for the DMA bus matrix. It routes one of `NUM_PORTS` input-stage requests to a shared AHB slave port. Arbitration is round-robin, burst-aware and lock-aware. It also generates the slave-side `HREADYMUXM` and the data-phase write-data mux. It sits between the input stages and each slave port, and replaces the fixed-priority two-port output stage plus its separate arbiter.

## Interface
- `NUM_PORTS`, 3, number of input ports (2..8)
- `ADDR_W`, 32, address width
- `DATA_W`, 32, write data width
- `PORT_W`, `$clog2(NUM_PORTS)`, port index width (derived; do not override)
- `HCLK`  in  1  clock
- `HRESETn`  in  1  reset: asynchronous, active-low
- `sel_op`  in  NUM_PORTS  per-port HSEL
- `held_tran_op`  in  NUM_PORTS  per-port held-transfer flag
- `addr_op`  in  NUM_PORTS*ADDR_W  per-port HADDR (port i at `[i*ADDR_W +: ADDR_W]`; same packing for all vectors)
- `trans_op`  in  NUM_PORTS*2  per-port HTRANS
- `write_op`  in  NUM_PORTS  per-port HWRITE
- `size_op`, `burst_op`  in  NUM_PORTS*3 each  HSIZE, HBURST
- `prot_op`, `master_op`  in  NUM_PORTS*4 each  HPROT, HMASTER
- `mastlock_op`  in  NUM_PORTS  per-port HMASTLOCK
- `wdata_op`  in  NUM_PORTS*DATA_W  per-port HWDATA
- `HREADYOUTM`  in  1  slave HREADYOUT
- `active_op`  out  NUM_PORTS  one-hot; the port currently owning the address phase
- `HSELM`, `HWRITEM`, `HMASTLOCKM`, `HREADYMUXM`  out  1 each  slave controls
- `HADDRM`  out  ADDR_W  slave address
- `HTRANSM`  out  2  slave transfer type
- `HSIZEM`, `HBURSTM`  out  3 each  slave size and burst
- `HPROTM`, `HMASTERM`  out  4 each  slave protection and master ID
- `HWDATAM`  out  DATA_W  slave write data

## Operation
- **Request:** `req[i] = sel_op[i] & held_tran_op[i]`.
- **Registered arbitration state:**
  - `addr_port` (PORT_W), `no_port`, `last_port` (round-robin pointer).
  - All update only when `HREADYMUXM`=1.
- **Hold condition.** The current grant is kept when `no_port`=0 and either:
  - the granted port's HTRANS is BUSY or SEQ (burst in progress), or
  - `hlock_arb`=1.
- **`hlock_arb` and `hsel_lock`:**
  - `hlock_arb = lock_sel & (hsel_lock | hsel_sel)`.
  - `hsel_lock` sets on a selected NONSEQ/SEQ locked transfer.
  - It clears when the selected port's mastlock=0.
  - It updates on `HREADYMUXM`=1.
- **Otherwise, round-robin:**
  - Grant the first `req[i]` scanning `last_port+1` upward, wrapping modulo `NUM_PORTS`, ending at `last_port`.
  - The granted port becomes both `addr_port` and `last_port`.
- **No request and no hold:** `no_port`=1; `addr_port` and `last_port` keep their values.
- **Address mux:**
  - When `no_port`=0, all address/control outputs mirror port `addr_port`, and `active_op` = one-hot(`addr_port`).
  - When `no_port`=1, all address/control outputs and `active_op` are 0.
- **Data mux:**
  - `data_port` <= `addr_port` when `HREADYMUXM`=1.
  - `HWDATAM` = `wdata_op[data_port]`.
- **HREADYMUXM:**
  - `slave_sel` <= `HSELM` when `HREADYMUXM`=1.
  - `HREADYMUXM = slave_sel ? HREADYOUTM : 1`.

## Timing
- **Reset values:**
  - State: `no_port`=1, `addr_port`=0, `last_port`=`NUM_PORTS-1` (port 0 wins first), `data_port`=0, `slave_sel`=0, `hsel_lock`=0.
  - Outputs: all address/control outputs 0, `active_op`=0, `HREADYMUXM`=1, `HWDATAM`=`wdata_op[0]`.
- **Grant latency:** `req` sampled at edge with `HREADYMUXM`=1 → outputs switch in the following cycle. Address mux is combinational from registered state.
- **`HREADYMUXM`=0:** all state frozen; new requests wait.
- **Burst:** no re-arbitration while the granted port presents SEQ/BUSY. IDLE or NONSEQ from that port permits a switch.
- **Lock:** the locked port is held even while its HSEL deasserts, until its mastlock drops.
- **Simultaneous requests:** exactly one grant, by round-robin order. Others see `active_op`=0 and keep `held_tran`.
- **Reset mid-burst:** asynchronous return to reset values; no output X.

## Structure
- Package `ahb_bm_pkg`: HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HBURST constants, and the `clog2` helper if the tool lacks `$clog2`.
- One sub-module, `ahb_rr_arbiter`: owns `addr_port`, `no_port`, `last_port` and the hold logic.
  - Inputs: `req`, `HREADYM`, granted `HTRANS`, `hlock_arb`.
- The output stage owns the muxes, `hsel_lock`, `data_port` and `slave_sel`.

## Test plan
- **Reset then single request:** reset, then `req[1]`=1 with NONSEQ to 0x2000_0000 → next cycle `active_op`=3'b010, `HADDRM`=0x2000_0000, `HSELM`=1.
- **Round-robin:** `req`=3'b111 held constantly with single NONSEQ transfers → grants cycle 0,1,2,0; no port granted twice before the others.
- **INCR4 burst:** port 0 runs an INCR4 burst while port 2 requests → port 0 keeps the grant for all 4 beats (NONSEQ, SEQ×3, including a BUSY); port 2 is granted the cycle after the last beat.
- **Locked sequence with HSEL gap:** port 1 asserts mastlock, deasserts HSEL for 2 cycles, then reselects → no other port is granted until mastlock=0.
- **Wait states:** `HREADYOUTM`=0 for 3 cycles during a port 0 write → `HREADYMUXM`=0 for those 3 cycles, `HWDATAM` stays `wdata_op[0]`, and the arbitration state does not change.
- **Reset mid-burst:** assert `HRESETn`=0 during a SEQ beat → all outputs go to reset values immediately; `HREADYMUXM`=1.

Source files
------------

// File: rtl/ahb_output_stage_rr_pkg.sv
// rtl/ahb_output_stage_rr_pkg.sv - shared AHB encodings for the DMA bus matrix
// Contents: HTRANS encodings, HBURST constants, and a clog2 helper for tools
// that lack $clog2.
package ahb_bm_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ahb_output_stage_rr_if.sv
// rtl/ahb_output_stage_rr_if.sv - bus bundle between input stages and one slave port
// Per-port vectors pack port i at [i*W +: W].
// modport master : output-stage view (consumes per-port requests, drives slave side)
// modport slave  : environment view (drives per-port requests and HREADYOUTM)
interface ahb_output_stage_rr_if #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    logic [NUM_PORTS-1:0]        sel_op;
    logic [NUM_PORTS-1:0]        held_tran_op;
    logic [NUM_PORTS*ADDR_W-1:0] addr_op;
    logic [NUM_PORTS*2-1:0]      trans_op;
    logic [NUM_PORTS-1:0]        write_op;
    logic [NUM_PORTS*3-1:0]      size_op;
    logic [NUM_PORTS*3-1:0]      burst_op;
    logic [NUM_PORTS*4-1:0]      prot_op;
    logic [NUM_PORTS*4-1:0]      master_op;
    logic [NUM_PORTS-1:0]        mastlock_op;
    logic [NUM_PORTS*DATA_W-1:0] wdata_op;
    logic                        HREADYOUTM;

    logic [NUM_PORTS-1:0]        active_op;
    logic                        HSELM;
    logic [ADDR_W-1:0]           HADDRM;
    logic [1:0]                  HTRANSM;
    logic                        HWRITEM;
    logic [2:0]                  HSIZEM;
    logic [2:0]                  HBURSTM;
    logic [3:0]                  HPROTM;
    logic [3:0]                  HMASTERM;
    logic                        HMASTLOCKM;
    logic                        HREADYMUXM;
    logic [DATA_W-1:0]           HWDATAM;

    modport master (
        input  sel_op, held_tran_op, addr_op, trans_op, write_op, size_op,
               burst_op, prot_op, master_op, mastlock_op, wdata_op, HREADYOUTM,
        output active_op, HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM,
               HPROTM, HMASTERM, HMASTLOCKM, HREADYMUXM, HWDATAM
    );

    modport slave (
        output sel_op, held_tran_op, addr_op, trans_op, write_op, size_op,
               burst_op, prot_op, master_op, mastlock_op, wdata_op, HREADYOUTM,
        input  active_op, HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM,
               HPROTM, HMASTERM, HMASTLOCKM, HREADYMUXM, HWDATAM
    );

endinterface

// File: rtl/ahb_output_stage_rr_arbiter.sv
// rtl/ahb_output_stage_rr_arbiter.sv - burst/lock-aware round-robin arbiter
// Ports:
//   HCLK, HRESETn  clock, asynchronous active-low reset
//   i_req          per-port request (HSEL & held transfer)
//   i_hreadym      slave-side HREADY; state only moves when high
//   i_htrans       HTRANS of the currently granted port (IDLE when none)
//   i_hlock_arb    granted port is inside a locked sequence
//   o_addr_port    port owning the address phase
//   o_no_port      no port owns the address phase
module ahb_rr_arbiter
    import ahb_bm_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int PORT_W    = 2
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic                 i_hreadym,
    input  logic [1:0]           i_htrans,
    input  logic                 i_hlock_arb,
    output logic [PORT_W-1:0]    o_addr_port,
    output logic                 o_no_port
);
    logic [PORT_W-1:0] r_addr_port;
    logic [PORT_W-1:0] r_last_port;
    logic              r_no_port;

    logic              w_hold;
    logic              w_found;
    logic [PORT_W-1:0] w_next;

    // A burst in flight (BUSY/SEQ) or a locked sequence pins the grant.
    assign w_hold = !r_no_port &&
                    ((i_htrans == TRANS_BUSY) || (i_htrans == TRANS_SEQ) || i_hlock_arb);

    // Scan from the port after the last winner, wrapping, ending on the last winner.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_next  = r_last_port;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = (int'(r_last_port) + k) % NUM_PORTS;
            if (!w_found && i_req[idx]) begin
                w_found = 1'b1;
                w_next  = PORT_W'(idx);
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_no_port   <= 1'b1;
            r_addr_port <= '0;
            r_last_port <= PORT_W'(NUM_PORTS - 1);
        end else if (i_hreadym && !w_hold) begin
            if (w_found) begin
                r_no_port   <= 1'b0;
                r_addr_port <= w_next;
                r_last_port <= w_next;
            end else begin
                r_no_port   <= 1'b1;
            end
        end
    end

    assign o_addr_port = r_addr_port;
    assign o_no_port   = r_no_port;

endmodule

// File: rtl/ahb_output_stage_rr.sv
// rtl/ahb_output_stage_rr.sv - round-robin bus-matrix output stage for one slave port
// Ports:
//   HCLK, HRESETn  clock, asynchronous active-low reset
//   bus            ahb_output_stage_rr_if.master: per-port requests in,
//                  shared slave address/control/write data and HREADYMUXM out
module ahb_output_stage_rr
    import ahb_bm_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    ahb_output_stage_rr_if.master bus
);
    localparam int PORT_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0] w_req;
    logic [PORT_W-1:0]    w_addr_port;
    logic                 w_no_port;

    logic [NUM_PORTS-1:0] w_active;
    logic                 w_hsel;
    logic [ADDR_W-1:0]    w_haddr;
    logic [1:0]           w_htrans;
    logic                 w_hwrite;
    logic [2:0]           w_hsize;
    logic [2:0]           w_hburst;
    logic [3:0]           w_hprot;
    logic [3:0]           w_hmaster;
    logic                 w_hmastlock;

    logic                 w_hreadymux;
    logic                 w_hlock_arb;
    logic                 w_lockable;

    logic [PORT_W-1:0]    r_data_port;
    logic                 r_slave_sel;
    logic                 r_hsel_lock;

    assign w_req = bus.sel_op & bus.held_tran_op;

    ahb_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_arbiter (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .i_req       (w_req),
        .i_hreadym   (w_hreadymux),
        .i_htrans    (w_htrans),
        .i_hlock_arb (w_hlock_arb),
        .o_addr_port (w_addr_port),
        .o_no_port   (w_no_port)
    );

    // Address/control mux: everything is zero while nobody owns the address phase.
    always_comb begin
        w_active    = '0;
        w_hsel      = 1'b0;
        w_haddr     = '0;
        w_htrans    = TRANS_IDLE;
        w_hwrite    = 1'b0;
        w_hsize     = 3'b000;
        w_hburst    = 3'b000;
        w_hprot     = 4'b0000;
        w_hmaster   = 4'b0000;
        w_hmastlock = 1'b0;
        if (!w_no_port) begin
            w_active    = NUM_PORTS'(1) << w_addr_port;
            w_hsel      = bus.sel_op[w_addr_port];
            w_haddr     = bus.addr_op[int'(w_addr_port)*ADDR_W +: ADDR_W];
            w_htrans    = bus.trans_op[int'(w_addr_port)*2 +: 2];
            w_hwrite    = bus.write_op[w_addr_port];
            w_hsize     = bus.size_op[int'(w_addr_port)*3 +: 3];
            w_hburst    = bus.burst_op[int'(w_addr_port)*3 +: 3];
            w_hprot     = bus.prot_op[int'(w_addr_port)*4 +: 4];
            w_hmaster   = bus.master_op[int'(w_addr_port)*4 +: 4];
            w_hmastlock = bus.mastlock_op[w_addr_port];
        end
    end

    // Once a locked transfer has been seen, hsel_lock keeps the grant across
    // cycles where the locked master drops HSEL, until it drops mastlock.
    assign w_lockable  = (w_htrans == TRANS_NONSEQ) || (w_htrans == TRANS_SEQ);
    assign w_hlock_arb = w_hmastlock & (r_hsel_lock | w_hsel);

    // Only a slave selected in the previous address phase may stall the bus.
    assign w_hreadymux = r_slave_sel ? bus.HREADYOUTM : 1'b1;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_data_port <= '0;
            r_slave_sel <= 1'b0;
            r_hsel_lock <= 1'b0;
        end else if (w_hreadymux) begin
            r_data_port <= w_addr_port;
            r_slave_sel <= w_hsel;
            if (w_hsel && w_hmastlock && w_lockable) begin
                r_hsel_lock <= 1'b1;
            end else if (!w_hmastlock) begin
                r_hsel_lock <= 1'b0;
            end
        end
    end

    assign bus.active_op  = w_active;
    assign bus.HSELM      = w_hsel;
    assign bus.HADDRM     = w_haddr;
    assign bus.HTRANSM    = w_htrans;
    assign bus.HWRITEM    = w_hwrite;
    assign bus.HSIZEM     = w_hsize;
    assign bus.HBURSTM    = w_hburst;
    assign bus.HPROTM     = w_hprot;
    assign bus.HMASTERM   = w_hmaster;
    assign bus.HMASTLOCKM = w_hmastlock;
    assign bus.HREADYMUXM = w_hreadymux;
    assign bus.HWDATAM    = bus.wdata_op[int'(r_data_port)*DATA_W +: DATA_W];

endmodule

// File: tb/tb_ahb_output_stage_rr.sv
// tb/tb_ahb_output_stage_rr.sv - scoreboard bench for ahb_output_stage_rr
module tb_ahb_output_stage_rr;
    import ahb_bm_pkg::*;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic HCLK;
    logic HRESETn;

    ahb_output_stage_rr_if #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    ahb_output_stage_rr #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial begin
        HCLK = 1'b1;
        forever #5 HCLK = ~HCLK;
    end

    // Per-port stimulus as seen by the input stages.
    logic        p_sel   [N];
    logic        p_held  [N];
    logic [1:0]  p_trans [N];
    logic [31:0] p_addr  [N];
    logic        p_write [N];
    logic [2:0]  p_size  [N];
    logic [2:0]  p_burst [N];
    logic [3:0]  p_prot  [N];
    logic [3:0]  p_master[N];
    logic        p_lock  [N];
    logic [31:0] p_wdata [N];
    logic        hreadyout;

    // Reference model: who owns the slave, round-robin pointer, lock memory,
    // whether the slave is in a data phase, and whose write data is on the bus.
    int m_port;
    bit m_idle;
    int m_ptr;
    bit m_lock;
    bit m_ssel;
    int m_dport;

    typedef struct {
        logic [N-1:0]  active;
        logic [AW-1:0] addr;
        logic [18:0]   ctrl;
        logic          rdy;
        logic [DW-1:0] wdata;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_port  = 0;
        m_idle  = 1;
        m_ptr   = N - 1;
        m_lock  = 0;
        m_ssel  = 0;
        m_dport = 0;
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        int p;
        e.active = '0;
        e.addr   = '0;
        e.ctrl   = '0;
        if (!m_idle) begin
            p = m_port;
            e.active[p] = 1'b1;
            e.addr = p_addr[p];
            e.ctrl = {p_sel[p], p_trans[p], p_write[p], p_size[p], p_burst[p],
                      p_prot[p], p_master[p], p_lock[p]};
        end
        e.rdy   = m_ssel ? hreadyout : 1'b1;
        e.wdata = p_wdata[m_dport];
        return e;
    endfunction

    function automatic void model_advance();
        bit own, in_burst, locked, found, new_lock;
        int p, c;
        if (m_ssel && !hreadyout) return;
        own      = !m_idle;
        p        = m_port;
        in_burst = own && (p_trans[p] == TRANS_BUSY || p_trans[p] == TRANS_SEQ);
        locked   = own && p_lock[p] && (m_lock || p_sel[p]);
        new_lock = m_lock;
        if (own && p_sel[p] && p_lock[p] && (p_trans[p] == TRANS_NONSEQ || p_trans[p] == TRANS_SEQ))
            new_lock = 1;
        else if (!own || !p_lock[p])
            new_lock = 0;
        m_lock  = new_lock;
        m_ssel  = own && p_sel[p];
        m_dport = m_port;
        if (!(in_burst || locked)) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (!found && p_sel[c] && p_held[c]) begin
                    found  = 1;
                    m_port = c;
                    m_ptr  = c;
                end
            end
            m_idle = !found;
        end
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.sel_op[i]            = p_sel[i];
            bus.held_tran_op[i]      = p_held[i];
            bus.addr_op[i*AW +: AW]  = p_addr[i];
            bus.trans_op[i*2 +: 2]   = p_trans[i];
            bus.write_op[i]          = p_write[i];
            bus.size_op[i*3 +: 3]    = p_size[i];
            bus.burst_op[i*3 +: 3]   = p_burst[i];
            bus.prot_op[i*4 +: 4]    = p_prot[i];
            bus.master_op[i*4 +: 4]  = p_master[i];
            bus.mastlock_op[i]       = p_lock[i];
            bus.wdata_op[i*DW +: DW] = p_wdata[i];
        end
        bus.HREADYOUTM = hreadyout;
    endtask

    // One clock: present inputs, queue the expected outputs, advance the model.
    task automatic step();
        drive();
        q.push_back(expect_now());
        if (HRESETn) model_advance();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drop(input int i);
        p_sel[i]   = 1'b0;
        p_held[i]  = 1'b0;
        p_trans[i] = TRANS_IDLE;
        p_lock[i]  = 1'b0;
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) begin
            drop(i);
            p_addr[i]   = '0;
            p_write[i]  = 1'b0;
            p_size[i]   = 3'd0;
            p_burst[i]  = HBURST_SINGLE;
            p_prot[i]   = 4'd0;
            p_master[i] = 4'd0;
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] tr, input logic [31:0] a,
                           input logic lk, input logic wr, input logic [2:0] bu);
        p_sel[i]    = 1'b1;
        p_held[i]   = 1'b1;
        p_trans[i]  = tr;
        p_addr[i]   = a;
        p_lock[i]   = lk;
        p_write[i]  = wr;
        p_burst[i]  = bu;
        p_size[i]   = 3'd2;
        p_prot[i]   = 4'h3;
        p_master[i] = 4'(i + 1);
    endtask

    always @(negedge HCLK) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("active_op", bus.active_op, e.active);
            chk("HADDRM", bus.HADDRM, e.addr);
            chk("ctrl", {bus.HSELM, bus.HTRANSM, bus.HWRITEM, bus.HSIZEM, bus.HBURSTM,
                         bus.HPROTM, bus.HMASTERM, bus.HMASTLOCKM}, e.ctrl);
            chk("HREADYMUXM", bus.HREADYMUXM, e.rdy);
            chk("HWDATAM", bus.HWDATAM, e.wdata);
        end
    end

    logic [N-1:0] rr_order [6];

    initial begin
        HRESETn   = 1'b1;
        hreadyout = 1'b1;
        idle_all();
        for (int i = 0; i < N; i++) p_wdata[i] = $urandom;
        rr_order = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};

        #1;
        HRESETn = 1'b0;
        model_reset();
        step();
        step();
        chk("reset_active", bus.active_op, 0);
        chk("reset_hsel", bus.HSELM, 0);
        chk("reset_haddr", bus.HADDRM, 0);
        chk("reset_hreadymux", bus.HREADYMUXM, 1);
        chk("reset_hwdata", bus.HWDATAM, p_wdata[0]);
        HRESETn = 1'b1;
        step();

        // Single request from port 1.
        set_req(1, TRANS_NONSEQ, 32'h2000_0000, 1'b0, 1'b0, HBURST_SINGLE);
        step();
        chk("single_active", bus.active_op, 3'b010);
        chk("single_haddr", bus.HADDRM, 32'h2000_0000);
        chk("single_hsel", bus.HSELM, 1);
        idle_all();
        step();
        step();

        // All ports requesting single transfers: pointer last sat on port 1.
        for (int i = 0; i < N; i++) set_req(i, TRANS_NONSEQ, 32'h100 * (i + 1), 1'b0, 1'b0, HBURST_SINGLE);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_order", bus.active_op, rr_order[k]);
        end
        idle_all();
        step();

        // INCR4 on port 0 with port 2 waiting.
        set_req(0, TRANS_NONSEQ, 32'h1000, 1'b0, 1'b0, HBURST_INCR4);
        step();
        set_req(2, TRANS_NONSEQ, 32'h3000, 1'b0, 1'b0, HBURST_SINGLE);
        p_trans[0] = TRANS_SEQ;  p_addr[0] = 32'h1004;
        step();
        chk("burst_hold_seq", bus.active_op, 3'b001);
        p_trans[0] = TRANS_BUSY; p_addr[0] = 32'h1008;
        step();
        chk("burst_hold_busy", bus.active_op, 3'b001);
        p_trans[0] = TRANS_SEQ;
        step();
        chk("burst_hold_seq2", bus.active_op, 3'b001);
        p_addr[0] = 32'h100C;
        step();
        chk("burst_hold_last", bus.active_op, 3'b001);
        drop(0);
        step();
        chk("burst_handover", bus.active_op, 3'b100);
        idle_all();
        step();

        // Locked sequence on port 1 with a two-cycle HSEL gap.
        set_req(1, TRANS_NONSEQ, 32'h4000, 1'b1, 1'b0, HBURST_SINGLE);
        step();
        set_req(0, TRANS_NONSEQ, 32'h7000, 1'b0, 1'b0, HBURST_SINGLE);
        set_req(2, TRANS_NONSEQ, 32'h8000, 1'b0, 1'b0, HBURST_SINGLE);
        p_addr[1] = 32'h4004;
        step();
        chk("lock_hold", bus.active_op, 3'b010);
        p_sel[1] = 1'b0; p_held[1] = 1'b0; p_trans[1] = TRANS_IDLE;
        step();
        chk("lock_gap1", bus.active_op, 3'b010);
        step();
        chk("lock_gap2", bus.active_op, 3'b010);
        p_sel[1] = 1'b1; p_held[1] = 1'b1; p_trans[1] = TRANS_NONSEQ; p_addr[1] = 32'h4008;
        step();
        chk("lock_reselect", bus.active_op, 3'b010);
        drop(1);
        step();
        chk("lock_release", bus.active_op, 3'b100);
        idle_all();
        step();

        // Port 0 write followed by three wait states.
        set_req(0, TRANS_NONSEQ, 32'h5000, 1'b0, 1'b1, HBURST_SINGLE);
        step();
        step();
        drop(0);
        set_req(1, TRANS_NONSEQ, 32'h5100, 1'b0, 1'b0, HBURST_SINGLE);
        set_req(2, TRANS_NONSEQ, 32'h5200, 1'b0, 1'b0, HBURST_SINGLE);
        hreadyout = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive();
            #1;
            chk("wait_hreadymux", bus.HREADYMUXM, 0);
            chk("wait_hwdata", bus.HWDATAM, p_wdata[0]);
            chk("wait_active", bus.active_op, 3'b001);
            step();
        end
        hreadyout = 1'b1;
        step();
        chk("wait_release", bus.active_op, 3'b010);
        idle_all();
        step();
        step();

        // Reset during a SEQ beat of port 2.
        set_req(2, TRANS_NONSEQ, 32'h6000, 1'b0, 1'b0, HBURST_INCR4);
        step();
        p_trans[2] = TRANS_SEQ; p_addr[2] = 32'h6004;
        step();
        chk("pre_reset_active", bus.active_op, 3'b100);
        HRESETn = 1'b0;
        model_reset();
        drive();
        #1;
        chk("midrst_active", bus.active_op, 0);
        chk("midrst_htrans", bus.HTRANSM, 0);
        chk("midrst_haddr", bus.HADDRM, 0);
        chk("midrst_hreadymux", bus.HREADYMUXM, 1);
        chk("midrst_hwdata", bus.HWDATAM, p_wdata[0]);
        step();
        HRESETn = 1'b1;
        step();

        // Randomised traffic, locks tend to persist for a few cycles.
        repeat (3000) begin
            for (int i = 0; i < N; i++) begin
                p_sel[i]    = ($urandom % 4) != 0;
                p_held[i]   = ($urandom % 4) != 0;
                p_trans[i]  = 2'($urandom_range(0, 3));
                p_addr[i]   = $urandom;
                p_write[i]  = 1'($urandom % 2);
                p_size[i]   = 3'($urandom_range(0, 7));
                p_burst[i]  = 3'($urandom_range(0, 7));
                p_prot[i]   = 4'($urandom_range(0, 15));
                p_master[i] = 4'($urandom_range(0, 15));
                p_lock[i]   = p_lock[i] ? (($urandom % 4) != 0) : (($urandom % 8) == 0);
                p_wdata[i]  = $urandom;
            end
            hreadyout = ($urandom % 5) != 0;
            if ($urandom_range(0, 299) == 0) begin
                HRESETn = 1'b0;
                model_reset();
            end else begin
                HRESETn = 1'b1;
            end
            step();
        end

        HRESETn = 1'b1;
        idle_all();
        step();
        @(negedge HCLK);
        #1;
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
